adder_share_arbiter: RTL and testbench
======================================

# adder_share_arbiter

Shares one `parallel_adder` datapath among R requesters. Each requester uses a valid/ready operand handshake, and the block returns each sum, carry-out and requester ID on a single valid/ready response channel. Only one operation is outstanding at a time. It sits between the combinational adder and the request sources, and owns all sequencing and arbitration for that adder.

## Interface
Parameters:
- `N`, 8: operand and sum width in bits; must be ≥ 1.
- `R`, 4: number of requesters; must be ≥ 2.
- `IDW`, derived: max(1, $clog2(R)); width of `rsp_id`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  R  per-requester operand-valid.
- `req_ready`  out  R  per-requester accept; at most one bit high.
- `req_a`  in  R*N  operand A; requester i occupies bits [i*N +: N].
- `req_b`  in  R*N  operand B; same packing as `req_a`.
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_sum`  out  N  A+B modulo 2^N.
- `rsp_cout`  out  1  carry out of bit N-1.
- `rsp_id`  out  IDW  index of the requester that owns the result.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE:**
  - If any `req_valid` is high, the arbiter selects exactly one requester g.
  - `req_ready[g]` is driven combinationally high in the same cycle; all other `req_ready` bits stay 0.
  - On that clock edge, `req_a[g]`, `req_b[g]` and g are captured into operand/ID registers, and the FSM moves to EXEC.
- **EXEC:**
  - The adder is driven from the operand registers.
  - On the edge, `sum` and `cout` are registered into the result registers; `rsp_valid` goes to 1 and the FSM moves to RESP.
- **RESP:**
  - `rsp_valid`, `rsp_sum`, `rsp_cout` and `rsp_id` are held stable until `rsp_valid && rsp_ready` is sampled on an edge.
  - On that edge the FSM returns to IDLE.
  - `req_ready` is all 0 in EXEC and RESP.
- **Arbitration:** round-robin (see Configuration).
  - Search starts at `last_grant + 1` and wraps modulo R.
  - `last_grant` updates only on an accept edge.
- **Requester behaviour:** a requester may drop `req_valid` before being granted. No state is kept for it and no penalty applies.
- **Arithmetic:** unsigned. The (N+1)-bit result is split as `{rsp_cout, rsp_sum}`.

## Timing
- Reset values:
  - FSM = IDLE, `last_grant` = R-1, so requester 0 wins first.
  - `rsp_valid` = 0, `rsp_sum` = 0, `rsp_cout` = 0, `rsp_id` = 0, `req_ready` = 0.
- **Latency:** accept edge at cycle t; `rsp_valid` is high from cycle t+2.
- **Throughput:** one operation per 3 cycles at best, when `rsp_ready` is held high.
- **Back-to-back:** a request waiting during the RESP-exit edge is granted combinationally in the following IDLE cycle. No other cycle is lost.
- **Reset mid-operation:** in EXEC or RESP, `rst` clears all state immediately. The in-flight result is discarded and `rsp_valid` falls without waiting for a clock.
- **Simultaneous events:** when all R requesters are valid, each is granted exactly once per R consecutive accepts.
- **Response stability:** `rsp_*` outputs must not change while `rsp_valid && !rsp_ready`.

## Configuration
- Macro `ADDER_ARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration with the `last_grant` pointer, as above.
- **Undefined:**
  - Fixed priority: the lowest asserted index wins.
  - The `last_grant` register is not built.
  - All other behaviour and timing is identical.

## Structure
- Shared package `adder_arb_pkg` contains:
  - the FSM state enum (IDLE/EXEC/RESP);
  - a width helper function for IDW.
- One sub-module, `adder_rr_arbiter`:
  - inputs: request vector, `last_grant`, enable;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- The top instantiates `parallel_adder #(N)` once and contains the FSM plus the operand and result registers.

## Test plan
- **Single request:** reset, then requester 0 sends A=0x55, B=0x28 → `req_ready[0]` pulses for 1 cycle; `rsp_valid` high 2 cycles after accept with `rsp_sum`=0x7D, `rsp_cout`=0, `rsp_id`=0.
- **Carry out:** requester 2 sends A=0xFF, B=0x01 → `rsp_sum`=0x00, `rsp_cout`=1, `rsp_id`=2.
- **Fairness:** all 4 requesters valid continuously, `rsp_ready`=1 → grant order 0,1,2,3,0. With the macro undefined, grant order is 0,0,0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles → `rsp_*` stable and all `req_ready`=0 throughout; raise `rsp_ready` → handshake, and the next grant follows in the next cycle.
- **Reset mid-operation:** assert `rst` during EXEC, and again during RESP → `rsp_valid` drops immediately; after release, requester 0 has priority.
- **Withdrawn request:** requester 1 raises `req_valid` during RESP, then drops it before IDLE → no grant and no response is produced for requester 1.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic int id_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/adder_rr_arbiter.sv
// Combinational rotating-priority arbiter: search starts one past last_grant.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int R   = 4,
  parameter int IDW = id_width(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  input  logic           en,
  output logic [R-1:0]   grant,
  output logic [IDW-1:0] grant_idx
);

  int   idx;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= R; k++) begin
      idx = (int'(last_grant) + k) % R;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/parallel_adder.sv
// Combinational N-bit unsigned adder with carry-out.
module parallel_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one parallel_adder among R valid/ready requesters, one operation in flight.
// ADDER_ARB_ROUND_ROBIN_EN selects round-robin arbitration; otherwise lowest index wins.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int N   = 8,
  parameter int R   = 4,
  parameter int IDW = id_width(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N-1:0]   rsp_sum,
  output logic           rsp_cout,
  output logic [IDW-1:0] rsp_id
);

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [IDW-1:0] id_q, id_d;
  logic [N-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic [R-1:0]   grant;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] last_grant;
  logic [N-1:0]   sel_a, sel_b;
  logic [N-1:0]   add_sum;
  logic           add_cout;

`ifdef ADDER_ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  // A pointer frozen at R-1 makes the rotating search plain lowest-index priority.
  assign last_grant = IDW'(R - 1);
`endif

  adder_rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .en         (state_q == IDLE),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  parallel_adder #(N) u_add (
    .a    (a_q),
    .b    (b_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < R; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*N +: N];
        sel_b = req_b[i*N +: N];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    rsp_valid_d = rsp_valid_q;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (|grant) begin
          a_d     = sel_a;
          b_d     = sel_b;
          id_d    = grant_idx;
          state_d = EXEC;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
          last_grant_d = grant_idx;
`endif
        end
      end
      EXEC: begin
        sum_d       = add_sum;
        cout_d      = add_cout;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
      last_grant_q <= IDW'(R - 1);
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef ADDER_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench: directed table, corner-case sequences and randomized traffic vs. a reference model.
module tb_adder_share_arbiter;

  localparam int N   = 8;
  localparam int R   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [R-1:0]   req_valid = '0;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a = '0;
  logic [R*N-1:0] req_b = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [N-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [IDW-1:0] rsp_id;

  adder_share_arbiter #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state: one job in flight, result due two cycles after its accept.
  bit           m_busy;
  int           m_acc;
  int           m_id;
  int           m_last;
  logic [N:0]   m_res;
  int           cyc;
  logic [R-1:0] last_rdy;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
  } vec_t;
  vec_t vecs[5];

  int gq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int pick(input logic [R-1:0] v);
`ifdef ADDER_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= R; k++)
      if (v[(m_last + k) % R]) return (m_last + k) % R;
`else
    for (int k = 0; k < R; k++)
      if (v[k]) return k;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_acc  = 0;
    m_id   = 0;
    m_last = R - 1;
    m_res  = '0;
  endtask

  // Apply one cycle of inputs, check outputs against the model, then advance the clock.
  task automatic cycle(input logic [R-1:0] v, input logic [R*N-1:0] av,
                       input logic [R*N-1:0] bv, input logic rr);
    int g;
    logic [R-1:0] exp_rdy;
    logic exp_rv;
    req_valid = v; req_a = av; req_b = bv; rsp_ready = rr;
    #1;
    exp_rdy = '0;
    g = -1;
    if (!m_busy && v != '0) begin
      g = pick(v);
      exp_rdy[g] = 1'b1;
    end
    exp_rv = m_busy && (cyc >= m_acc + 2);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rsp_sum", 32'(rsp_sum), 32'(m_res[N-1:0]));
      chk("rsp_cout", 32'(rsp_cout), 32'(m_res[N]));
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
    end
    $display("cyc %0d valid=%b ready=%b rsp_valid=%b rsp_ready=%b id=%0d sum=%h cout=%b",
             cyc, v, req_ready, rsp_valid, rr, rsp_id, rsp_sum, rsp_cout);
    last_rdy = req_ready;
    if (g >= 0) begin
      m_busy = 1;
      m_acc  = cyc;
      m_id   = g;
      m_res  = {1'b0, av[g*N +: N]} + {1'b0, bv[g*N +: N]};
      m_last = g;
    end else if (exp_rv && rr) begin
      m_busy = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0; rsp_ready = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_req_ready", 32'(req_ready), 0);
    chk("reset_rsp_sum", 32'(rsp_sum), 0);
    chk("reset_rsp_cout", 32'(rsp_cout), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    rst = 1'b0;
  endtask

  function automatic logic [R*N-1:0] place(input int id, input logic [N-1:0] x);
    logic [R*N-1:0] r;
    r = '0;
    r[id*N +: N] = x;
    return r;
  endfunction

  function automatic logic [R*N-1:0] rnd_ops();
    logic [R*N-1:0] r;
    for (int i = 0; i < R; i++) r[i*N +: N] = N'($urandom);
    return r;
  endfunction

  initial begin
    logic [R*N-1:0] av, bv;
    int g;
    int exp_fair[5];

    cyc = 0;
    model_reset();
    vecs[0] = '{0, 8'h55, 8'h28, 8'h7D, 1'b0};
    vecs[1] = '{2, 8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[2] = '{3, 8'h80, 8'h80, 8'h00, 1'b1};
    vecs[3] = '{1, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{3, 8'h7F, 8'h01, 8'h80, 1'b0};

    do_reset();

    // Directed single transactions: accept, EXEC, then response checked against the table.
    for (int i = 0; i < 5; i++) begin
      cycle(R'(1) << vecs[i].id, place(vecs[i].id, vecs[i].a), place(vecs[i].id, vecs[i].b), 1'b0);
      chk("tbl_accept_ready", 32'(last_rdy), 32'(R'(1) << vecs[i].id));
      cycle('0, '0, '0, 1'b0);
      #1;
      chk("tbl_rsp_valid", 32'(rsp_valid), 1);
      chk("tbl_rsp_sum", 32'(rsp_sum), 32'(vecs[i].sum));
      chk("tbl_rsp_cout", 32'(rsp_cout), 32'(vecs[i].cout));
      chk("tbl_rsp_id", 32'(rsp_id), 32'(vecs[i].id));
      cycle('0, '0, '0, 1'b1);
      cycle('0, '0, '0, 1'b0);
    end

    // Fairness: every requester valid, consumer always ready.
    do_reset();
    gq.delete();
    for (int c = 0; c < 40 && gq.size() < 5; c++) begin
      cycle('1, rnd_ops(), rnd_ops(), 1'b1);
      for (int i = 0; i < R; i++) if (last_rdy[i]) gq.push_back(i);
    end
`ifdef ADDER_ARB_ROUND_ROBIN_EN
    exp_fair = '{0, 1, 2, 3, 0};
`else
    exp_fair = '{0, 0, 0, 0, 0};
`endif
    chk("fair_grant_count", 32'(gq.size()), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("fair_order", 32'(gq[i]), 32'(exp_fair[i]));
    for (int c = 0; c < 3; c++) cycle('0, '0, '0, 1'b1);

    // Backpressure: response held five cycles while requester 3 waits.
    do_reset();
    cycle(4'b0001, place(0, 8'h12), place(0, 8'h34), 1'b0);
    cycle('0, '0, '0, 1'b0);
    for (int c = 0; c < 5; c++) cycle(4'b1000, place(3, 8'h01), place(3, 8'h02), 1'b0);
    cycle(4'b1000, place(3, 8'h01), place(3, 8'h02), 1'b1);
    cycle(4'b1000, place(3, 8'h01), place(3, 8'h02), 1'b1);
    chk("bp_next_grant", 32'(last_rdy), 32'(4'b1000));
    for (int c = 0; c < 3; c++) cycle('0, '0, '0, 1'b1);

    // Reset during EXEC, then during RESP; requester 0 must regain priority.
    do_reset();
    cycle(4'b0010, place(1, 8'h01), place(1, 8'h01), 1'b1);
    cycle('0, '0, '0, 1'b1);
    cycle('0, '0, '0, 1'b1);
    av = place(0, 8'h10) | place(2, 8'h20);
    bv = place(0, 8'h01) | place(2, 8'h02);
    cycle(4'b0101, av, bv, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst_exec_rsp_valid", 32'(rsp_valid), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(4'b0101, av, bv, 1'b0);
    chk("rst_exec_prio0", 32'(last_rdy), 32'(4'b0001));
    cycle('0, '0, '0, 1'b0);
    #1;
    chk("rst_resp_valid_before", 32'(rsp_valid), 1);
    rst = 1'b1;
    #1;
    chk("rst_resp_valid_after", 32'(rsp_valid), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(4'b0101, av, bv, 1'b1);
    chk("rst_resp_prio0", 32'(last_rdy), 32'(4'b0001));
    for (int c = 0; c < 3; c++) cycle('0, '0, '0, 1'b1);

    // Withdrawn request: requester 1 valid only while the block is in RESP.
    do_reset();
    cycle(4'b0001, place(0, 8'h01), place(0, 8'h02), 1'b0);
    cycle('0, '0, '0, 1'b0);
    cycle(4'b0010, place(1, 8'hAA), place(1, 8'h11), 1'b0);
    cycle('0, '0, '0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      cycle('0, '0, '0, 1'b1);
      chk("withdrawn_no_grant", 32'(last_rdy), 0);
    end

    // Randomized traffic, including requests that are dropped before being granted.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      g = int'($urandom_range(0, 3));
      cycle((g == 0) ? '0 : R'($urandom), rnd_ops(), rnd_ops(), ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
